// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions for the load/store unit:
//   - func3 encodings for loads and stores (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - lsu_state_t : LSU transaction state machine encoding
//   - acc_size_t  : access width decoded from func3
//   - access_size : func3 -> access width (reserved encodings map to word)
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Byte and halfword come in signed/unsigned flavours; every other
    // encoding (including the reserved ones) is treated as a word access.
    function automatic acc_size_t access_size(input logic [2:0] func3);
        case (func3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load extraction: selects the byte/halfword addressed by
// addr_lo out of the bus word and sign- or zero-extends it per func3.
// Ports:
//   rsp_data [31:0] in  : raw word returned by the data bus
//   func3    [2:0]  in  : load type (LB/LH/LW/LBU/LHU, reserved -> word)
//   addr_lo  [1:0]  in  : byte offset of the access inside the word
//   rdata    [31:0] out : aligned, extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rsp_data,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] rdata
);

    // Move the addressed lane down to bit 0 so extraction is a fixed slice.
    logic [31:0] shifted;
    assign shifted = rsp_data >> {addr_lo, 3'b000};

    always_comb begin
        // NOTE: assign a default before the case so no path leaves rdata
        // unassigned, which would infer a latch.
        rdata = rsp_data;
        case (func3)
            F3_B:    rdata = {{24{shifted[7]}},  shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = rsp_data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit bridging a single-issue core to a valid/ready data bus.
// One access at a time: IDLE latches the request, REQ presents it on the bus,
// WAIT collects a load response, DONE releases the stall for one cycle.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus and pulse misalign
//               during DONE.
//   undefined : no misalign port; offending low address bits are cleared.
//
// Ports:
//   clk, rst (sync, active-high)
//   core  : mem_read, mem_write, func3[2:0], addr[31:0], wdata[31:0] (in)
//           stall, rdata[31:0], misalign (macro only) (out)
//   bus   : d_req_valid, d_addr[31:0], d_we, d_wstrb[3:0], d_wdata[31:0] (out)
//           d_req_ready, d_rsp_valid, d_rsp_data[31:0] (in)
// -----------------------------------------------------------------------------
module lsu
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        d_req_valid,
    input  logic        d_req_ready,
    output logic [31:0] d_addr,
    output logic        d_we,
    output logic [3:0]  d_wstrb,
    output logic [31:0] d_wdata,
    input  logic        d_rsp_valid,
    input  logic [31:0] d_rsp_data
);

    lsu_state_t  state, state_nxt;
    logic [31:0] addr_q;
    logic [2:0]  func3_q;
    logic [31:0] wdata_q;
    logic        store_q;

    logic        req_in;
    logic        trap_in;
    logic [31:0] addr_eff;
    acc_size_t   size_in;
    acc_size_t   size_q;
    logic [31:0] load_data;

    assign req_in  = mem_read | mem_write;
    assign size_in = access_size(func3);
    assign size_q  = access_size(func3_q);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap_in  = (size_in == SZ_HALF && addr[0]) ||
                      (size_in == SZ_WORD && addr[1:0] != 2'b00);
    assign addr_eff = addr;
    assign misalign = (state == DONE) && mis_q;
`else
    assign trap_in = 1'b0;

    // Silently align: clear the offset bits the access width cannot use.
    always_comb begin
        addr_eff = addr;
        case (size_in)
            SZ_HALF: addr_eff[0]   = 1'b0;
            SZ_WORD: addr_eff[1:0] = 2'b00;
            default: ;
        endcase
    end
`endif

    // -------------------------------------------------------------------------
    // State register and request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            rdata   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_in) begin
                addr_q  <= addr_eff;
                func3_q <= func3;
                wdata_q <= wdata;
                // A simultaneous read and write is handled as a store.
                store_q <= mem_write;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q   <= trap_in;
`endif
            end
            if (state == WAIT && d_rsp_valid) begin
                rdata <= load_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_in)      state_nxt = trap_in ? DONE : REQ;
            REQ:  if (d_req_ready) state_nxt = store_q ? DONE : WAIT;
            WAIT: if (d_rsp_valid) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus request outputs; driven from the latched copy so they stay stable
    // while the core or the bus stalls.
    // -------------------------------------------------------------------------
    logic [3:0]  strb_q;
    logic [31:0] store_data_q;

    always_comb begin
        strb_q       = 4'b1111;
        store_data_q = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                strb_q       = 4'b0001 << addr_q[1:0];
                store_data_q = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                strb_q       = 4'b0011 << {addr_q[1], 1'b0};
                store_data_q = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign d_req_valid = (state == REQ);
    assign d_we        = (state == REQ) && store_q;
    assign d_wstrb     = d_we ? strb_q : 4'b0000;
    assign d_addr      = {addr_q[31:2], 2'b00};
    assign d_wdata     = store_data_q;

    // The core is released only in DONE; outside a request there is nothing
    // to hold.
    assign stall = req_in && (state != DONE);

    lsu_load_align u_load_align (
        .rsp_data (d_rsp_data),
        .func3    (func3_q),
        .addr_lo  (addr_q[1:0]),
        .rdata    (load_data)
    );

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu. Each access pushes its expected bus request
// and (for loads) its expected rdata into scoreboard queues; they are popped
// and compared when the DUT accepts the request or releases the stall.
// -----------------------------------------------------------------------------
module tb_lsu;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif
    logic        d_req_valid, d_req_ready, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_req_t;

    bus_req_t    req_q[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;

    lsu dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .func3       (func3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign    (misalign),
`endif
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_addr      (d_addr),
        .d_we        (d_we),
        .d_wstrb     (d_wstrb),
        .d_wdata     (d_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data)
    );

    // Reference load result built byte-by-byte from the bus word.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // One complete access with a scripted bus: ready after ready_wait cycles
    // of REQ, load response in the cycle after acceptance.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              input int ready_wait, input logic [31:0] rsp,
                              input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                              input int exp_stall);
        bus_req_t er;
        bus_req_t front;
        int       stall_cnt = 0;
        int       wait_cnt  = 0;
        bit       done      = 1'b0;
        bit       rsp_now   = 1'b0;
        bit       is_store;
        is_store  = wr;
        er.addr   = exp_addr;
        er.we     = is_store;
        er.strb   = is_store ? exp_strb : 4'b0000;
        er.wdata  = exp_wdata;
        req_q.push_back(er);
        if (!is_store) rd_q.push_back(exp_rdata);

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            d_rsp_valid = rsp_now;
            d_rsp_data  = rsp_now ? rsp : 32'h0;
            rsp_now     = 1'b0;
            d_req_ready = d_req_valid && (wait_cnt >= ready_wait);
            @(negedge clk);
            if (d_req_valid) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s unexpected_request: d_req_valid=1 with nothing expected", name);
                end else begin
                    front = req_q[0];
                    checks++;
                    if (d_addr !== front.addr) begin
                        errors++; $display("FAIL %s d_addr: got %h expected %h", name, d_addr, front.addr);
                    end
                    checks++;
                    if (d_we !== front.we) begin
                        errors++; $display("FAIL %s d_we: got %b expected %b", name, d_we, front.we);
                    end
                    checks++;
                    if (d_wstrb !== front.strb) begin
                        errors++; $display("FAIL %s d_wstrb: got %b expected %b", name, d_wstrb, front.strb);
                    end
                    if (is_store) begin
                        checks++;
                        if (d_wdata !== front.wdata) begin
                            errors++; $display("FAIL %s d_wdata: got %h expected %h", name, d_wdata, front.wdata);
                        end
                    end
                    if (d_req_ready) begin
                        void'(req_q.pop_front());
                        rsp_now = !is_store;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
            if (stall) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                if (!is_store && rd_q.size() != 0) begin
                    logic [31:0] exp_rd;
                    exp_rd = rd_q.pop_front();
                    checks++;
                    if (rdata !== exp_rd) begin
                        errors++; $display("FAIL %s rdata: got %h expected %h", name, rdata, exp_rd);
                    end
                end
            end
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; d_req_ready = 1'b0; d_rsp_valid = 1'b0;

        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout: stall never released within 64 cycles", name);
        end
        checks++;
        if (stall_cnt != exp_stall) begin
            errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
        end
        checks++;
        if (req_q.size() != 0) begin
            errors++; $display("FAIL %s bus_request: got none accepted expected one", name);
        end
        req_q.delete();
        rd_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; d_req_ready = 1'b0; d_rsp_valid = 1'b0; d_rsp_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (d_req_valid !== 1'b0) begin errors++; $display("FAIL reset d_req_valid: got %b expected 0", d_req_valid); end
        checks++; if (d_we !== 1'b0) begin errors++; $display("FAIL reset d_we: got %b expected 0", d_we); end
        checks++; if (d_wstrb !== 4'b0) begin errors++; $display("FAIL reset d_wstrb: got %b expected 0000", d_wstrb); end
        checks++; if (d_addr !== 32'h0) begin errors++; $display("FAIL reset d_addr: got %h expected 0", d_addr); end
        checks++; if (d_wdata !== 32'h0) begin errors++; $display("FAIL reset d_wdata: got %h expected 0", d_wdata); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset rdata: got %h expected 0", rdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", stall); end
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset misalign: got %b expected 0", misalign); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_sb;
        run_access("sb_0x103", 1'b0, 1'b1, F3_B, 32'h103, 32'h000000AB, 0, 32'h0,
                   32'h100, 4'b1000, 32'hABABABAB, 32'h0, 2);
    endtask

    task automatic test_load_byte;
        run_access("lb_0x101", 1'b1, 1'b0, F3_B, 32'h101, 32'h0, 0, 32'h0000F700,
                   32'h100, 4'b0000, 32'h0, 32'hFFFFFFF7, 3);
        run_access("lbu_0x101", 1'b1, 1'b0, F3_BU, 32'h101, 32'h0, 0, 32'h0000F700,
                   32'h100, 4'b0000, 32'h0, 32'h000000F7, 3);
    endtask

    task automatic test_back_pressure;
        run_access("lh_0x202_bp", 1'b1, 1'b0, F3_H, 32'h202, 32'h0, 4, 32'h80010000,
                   32'h200, 4'b0000, 32'h0, 32'hFFFF8001, 7);
        run_access("sw_bp", 1'b0, 1'b1, F3_W, 32'h40, 32'h11223344, 3, 32'h0,
                   32'h40, 4'b1111, 32'h11223344, 32'h0, 5);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; func3 = F3_W; addr = 32'h10;
        @(posedge clk); #1;
        d_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (d_req_valid !== 1'b1) begin errors++; $display("FAIL rst_mid req_valid: got %b expected 1", d_req_valid); end
        @(posedge clk); #1;
        d_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid wait_stall: got %b expected 1", stall); end
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; d_rsp_valid = 1'b1; d_rsp_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid idle_stall: got %b expected 0", stall); end
        checks++; if (d_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid idle_req: got %b expected 0", d_req_valid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid rdata_cleared: got %h expected 0", rdata); end
        @(posedge clk); #1;
        d_rsp_valid = 1'b0; d_rsp_data = 32'h0;
        @(negedge clk);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid late_rsp_rdata: got %h expected 0", rdata); end
        checks++; if (d_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid late_rsp_req: got %b expected 0", d_req_valid); end
        mem_read = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid stall_follows_read: got %b expected 1", stall); end
        mem_read = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid stall_drops: got %b expected 0", stall); end
    endtask

    task automatic test_store_sizes;
        run_access("sb_off0", 1'b0, 1'b1, F3_B, 32'h400, 32'h5A5A5A11, 0, 32'h0, 32'h400, 4'b0001, 32'h11111111, 32'h0, 2);
        run_access("sb_off1", 1'b0, 1'b1, F3_B, 32'h401, 32'h00000022, 1, 32'h0, 32'h400, 4'b0010, 32'h22222222, 32'h0, 3);
        run_access("sb_off2", 1'b0, 1'b1, F3_B, 32'h402, 32'hFFFFFF33, 0, 32'h0, 32'h400, 4'b0100, 32'h33333333, 32'h0, 2);
        run_access("sh_off0", 1'b0, 1'b1, F3_H, 32'h500, 32'h9999BEEF, 0, 32'h0, 32'h500, 4'b0011, 32'hBEEFBEEF, 32'h0, 2);
        run_access("sh_off2", 1'b0, 1'b1, F3_H, 32'h502, 32'h0000C0DE, 2, 32'h0, 32'h500, 4'b1100, 32'hC0DEC0DE, 32'h0, 4);
        run_access("sw_rsvd011", 1'b0, 1'b1, 3'b011, 32'h600, 32'hA5A5F00F, 0, 32'h0, 32'h600, 4'b1111, 32'hA5A5F00F, 32'h0, 2);
        // Read and write asserted together must behave as a store.
        run_access("rw_both_store", 1'b1, 1'b1, F3_W, 32'h700, 32'h01020304, 0, 32'h0, 32'h700, 4'b1111, 32'h01020304, 32'h0, 2);
    endtask

    task automatic test_load_sizes;
        logic [2:0]  f3s[8];
        logic [31:0] d, a;
        int          sz;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 8; i++) begin
            sz = (f3s[i][1:0] == 2'b00) ? 1 : ((f3s[i][1:0] == 2'b01) ? 2 : 4);
            for (int off = 0; off < 4; off++) begin
                if (off % sz == 0) begin
                    d = $urandom;
                    a = 32'h800 + 32'(i * 16) + 32'(off);
                    run_access("load_sizes", 1'b1, 1'b0, f3s[i], a, 32'h0, i % 2, d,
                               {a[31:2], 2'b00}, 4'b0000, 32'h0,
                               load_model(f3s[i], 2'(off), d), 3 + (i % 2));
                end
            end
        end
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign_trap;
        int  stall_cnt = 0;
        int  mis_cnt   = 0;
        int  req_seen  = 0;
        bit  done      = 1'b0;
        bit  mis_at_done = 1'b0;
        @(posedge clk); #1;
        mem_write = 1'b1; mem_read = 1'b0; func3 = F3_W; addr = 32'h6; wdata = 32'h12345678;
        d_req_ready = 1'b1;
        for (int cyc = 0; cyc < 8 && !done; cyc++) begin
            @(negedge clk);
            if (d_req_valid) req_seen++;
            if (misalign) mis_cnt++;
            if (stall) stall_cnt++;
            else begin done = 1'b1; mis_at_done = misalign; end
            @(posedge clk); #1;
        end
        mem_write = 1'b0; d_req_ready = 1'b0;
        @(negedge clk);
        if (misalign) mis_cnt++;
        checks++; if (!done) begin errors++; $display("FAIL trap timeout: stall never released"); end
        checks++; if (req_seen != 0) begin errors++; $display("FAIL trap bus_skipped: got %0d request cycles expected 0", req_seen); end
        checks++; if (stall_cnt != 1) begin errors++; $display("FAIL trap stall_cycles: got %0d expected 1", stall_cnt); end
        checks++; if (mis_at_done !== 1'b1) begin errors++; $display("FAIL trap misalign_in_done: got %b expected 1", mis_at_done); end
        checks++; if (mis_cnt != 1) begin errors++; $display("FAIL trap misalign_pulse_len: got %0d expected 1", mis_cnt); end
    endtask
`else
    task automatic test_align_force;
        run_access("sw_0x6_forced", 1'b0, 1'b1, F3_W, 32'h6, 32'h12345678, 0, 32'h0,
                   32'h4, 4'b1111, 32'h12345678, 32'h0, 2);
        run_access("sh_0x101_forced", 1'b0, 1'b1, F3_H, 32'h101, 32'h0000BEEF, 0, 32'h0,
                   32'h100, 4'b0011, 32'hBEEFBEEF, 32'h0, 2);
        run_access("lh_0x203_forced", 1'b1, 1'b0, F3_H, 32'h203, 32'h0, 0, 32'h80010000,
                   32'h200, 4'b0000, 32'h0, 32'hFFFF8001, 3);
        run_access("lw_0x207_forced", 1'b1, 1'b0, F3_W, 32'h207, 32'h0, 0, 32'hCAFEF00D,
                   32'h204, 4'b0000, 32'h0, 32'hCAFEF00D, 3);
    endtask
`endif

    initial begin
        test_reset();
        test_store_sb();
        test_load_byte();
        test_back_pressure();
        test_reset_mid();
        test_store_sizes();
        test_load_sizes();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign_trap();
`else
        test_align_force();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have core-side inputs: mem_read  in  1  load request; mem_write  in  1  store request; func3  in  3  access size/sign; addr  in  32  byte address; wdata  in  32  store data.
REQ-003 SHALL have core-side outputs: stall  out  1  hold PC/pipeline; rdata  out  32  aligned, extended load result; misalign  out  1  misaligned access (LSU_MISALIGN_TRAP_EN only).
REQ-004 SHALL have bus ports: d_req_valid  out  1; d_req_ready  in  1; d_addr  out  32  word-aligned; d_we  out  1; d_wstrb  out  4; d_wdata  out  32; d_rsp_valid  in  1; d_rsp_data  in  32.

Function
REQ-005 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-006 IDLE: on mem_read|mem_write, latch addr, func3, wdata and op type, then go to REQ on the next edge; otherwise stay.
REQ-007 mem_read and mem_write both high SHALL be treated as a store.
REQ-008 REQ: d_req_valid=1, with d_addr, d_we, d_wstrb, d_wdata held stable until d_req_ready=1; on acceptance a store goes to DONE and a load goes to WAIT.
REQ-009 WAIT: on d_rsp_valid=1, capture the extracted load value into rdata and go to DONE.
REQ-010 d_rsp_valid SHALL be ignored outside WAIT.
REQ-011 DONE: stall=0 for exactly one cycle, rdata valid, then go to IDLE; a new request SHALL NOT be latched in DONE.
REQ-012 stall = (mem_read|mem_write) & (state != DONE), combinational.
REQ-013 Minimum stall with zero-wait memory: 2 cycles for a store, 3 cycles for a load.
REQ-014 d_addr = {addr[31:2], 2'b00}.
REQ-015 Store func3 000 (SB): wstrb = 4'b0001 << addr[1:0], byte replicated x4.
REQ-016 Store func3 001 (SH): wstrb = 4'b0011 << {addr[1],1'b0}, halfword replicated x2.
REQ-017 Store func3 010 (SW): wstrb = 4'b1111.
REQ-018 Load func3 000/001: byte/half selected by addr[1:0], sign-extended.
REQ-019 Load func3 100/101: byte/half selected by addr[1:0], zero-extended.
REQ-020 Load func3 010: full word.
REQ-021 Reserved func3 (011, 110, 111) SHALL behave as word access.
REQ-022 d_we=1 only in REQ for a store; d_wstrb=0 for loads.

Reset
REQ-023 At the rst edge: state=IDLE; d_req_valid=0; d_we=0; d_wstrb=0; d_addr=0; d_wdata=0; rdata=0; misalign=0.
REQ-024 rst mid-transaction SHALL abandon it without waiting for a bus response; a late d_rsp_valid SHALL be ignored.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN defined: halfword at addr[0]=1 or word at addr[1:0]!=0 SHALL skip the bus, go IDLE->DONE, and pulse misalign=1 during DONE.
REQ-026 Macro undefined: no misalign port; offending low address bits are forced to zero (half: addr[0]; word: addr[1:0]).

Structure
REQ-027 Package rv32i_pkg SHALL hold the func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu_state_t enum.
REQ-028 Load extraction/extension SHALL be a combinational sub-module lsu_load_align(rsp_data, func3, addr_lo -> rdata).

Verification
REQ-029 SB addr=0x103, wdata=0x000000AB, ready=1 -> d_addr=0x100, wstrb=1000, d_wdata=0xABABABAB, stall high for 2 cycles.
REQ-030 LB addr=0x101, rsp=0x0000F700 one cycle after acceptance -> rdata=0xFFFFFFF7; LBU with the same access -> 0x000000F7; stall high for 3 cycles.
REQ-031 LH addr=0x202, d_req_ready low for 4 cycles -> request fields stable, no acceptance; rsp=0x8001_0000 -> rdata=0xFFFF8001.
REQ-032 rst in WAIT, then d_rsp_valid pulse -> state IDLE, rdata=0, stall tracks mem_read only.
REQ-033 With macro: SW addr=0x6 -> no d_req_valid, misalign pulse 1 cycle. Without macro: same access -> d_addr=0x4, wstrb=1111.
